// File: rtl/averager_sequencer.sv
// averager_sequencer
// Run controller for the averaging core. It arms the averager with a
// one-cycle restart, gates the ADC sample-valid stream into it while
// accumulating, freezes the result once the host-programmed number of
// averages has been reached, and waits for the host to acknowledge readout.
// A watchdog aborts runs that stall, and completed acquisitions are counted.
// Every output comes straight from a flip-flop so the host register bank and
// the averager see glitch-free, cycle-aligned control.

module averager_sequencer #(
    parameter int WIDTH    = 8,
    parameter int N_WIDTH  = 24,
    parameter int TO_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                continuous,
    input  logic [N_WIDTH-1:0]  n_target,
    input  logic [TO_WIDTH-1:0] timeout,
    input  logic                ack,
    input  logic                tvalid_in,
    input  logic [N_WIDTH-1:0]  n_avg,
    input  logic                avg_ready,
    output logic                tvalid_out,
    output logic                restart,
    output logic                busy,
    output logic                done,
    output logic                timed_out,
    output logic [15:0]         acq_count,
    output logic [2:0]          state
);

    // The averager's completed-average counter is 32-WIDTH bits wide, so the
    // target and n_avg buses must match it exactly.
    localparam int AVG_N_WIDTH = 32 - WIDTH;

    generate
        if (N_WIDTH != AVG_N_WIDTH) begin : g_width_check
            $error("averager_sequencer: N_WIDTH must equal 32-WIDTH");
        end
    endgenerate

    // State encodings are visible on the debug port, so they are fixed values.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_ACCUM  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [N_WIDTH-1:0]  TARGET_ONE = {{(N_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0] TO_ONE     = {{(TO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TO_WIDTH-1:0] TO_ZERO    = '0;
    localparam logic [15:0]         ACQ_ONE    = 16'd1;

    logic [2:0]          state_next;
    logic [N_WIDTH-1:0]  target;
    logic [TO_WIDTH-1:0] wd_count;
    logic                wd_active;
    logic                wd_trip;
    logic                accum_exit;
    logic                entering_settle;
    logic                entering_done;
    logic                start_accepted;

    // Watchdog and exit qualifiers. The watchdog trips on the cycle that
    // completes the programmed number of SETTLE/ACCUM cycles, so the abort is
    // visible exactly 'timeout' cycles after SETTLE was entered.
    always_comb begin
        wd_active       = (state == ST_SETTLE) || (state == ST_ACCUM);
        wd_trip         = wd_active && (timeout != TO_ZERO) &&
                          (wd_count >= (timeout - TO_ONE));
        accum_exit      = (n_avg >= target) && avg_ready;
        start_accepted  = (state == ST_IDLE) && start && !stop;
    end

    // Next-state selection: stop overrides everything, the watchdog overrides
    // the normal handshakes, and start/ack are only honoured in their own
    // states.
    always_comb begin
        state_next = state;
        if (stop) begin
            state_next = ST_IDLE;
        end else if (wd_trip) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_ARM;
                    end
                end
                ST_ARM: begin
                    state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (n_avg == '0) begin
                        state_next = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accum_exit) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_next = continuous ? ST_ARM : ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Transition markers used by the counters below.
    always_comb begin
        entering_settle = (state_next == ST_SETTLE) && (state != ST_SETTLE);
        entering_done   = (state_next == ST_DONE) && (state != ST_DONE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the averaging target while arming so host writes during a run
    // only affect the next acquisition; a target of zero means one average.
    always_ff @(posedge clk) begin
        if (rst) begin
            target <= TARGET_ONE;
        end else if (state == ST_ARM) begin
            target <= (n_target == '0) ? TARGET_ONE : n_target;
        end
    end

    // Watchdog cycle counter: cleared when SETTLE is entered, then counts
    // every SETTLE/ACCUM cycle and sticks at its maximum value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count <= '0;
        end else if (entering_settle) begin
            wd_count <= '0;
        end else if (wd_active && (wd_count != '1)) begin
            wd_count <= wd_count + TO_ONE;
        end
    end

    // Restart is issued for the single ARM cycle; it is derived from the next
    // state so it lines up with the ARM state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            restart <= 1'b0;
        end else begin
            restart <= (state_next == ST_ARM);
        end
    end

    // Sample-valid gate: pass tvalid_in with one cycle of latency only while
    // the sequencer stays in ACCUM, so the buffer freezes the moment DONE,
    // stop or a watchdog abort is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_out <= 1'b0;
        end else begin
            tvalid_out <= (state == ST_ACCUM) && (state_next == ST_ACCUM) && tvalid_in;
        end
    end

    // Host status flags follow the state the sequencer is moving into.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != ST_IDLE);
            done <= (state_next == ST_DONE);
        end
    end

    // Sticky watchdog flag: set on an abort, cleared only by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            timed_out <= 1'b0;
        end else if (start_accepted) begin
            timed_out <= 1'b0;
        end else if (!stop && wd_trip) begin
            timed_out <= 1'b1;
        end
    end

    // Completed-acquisition counter, bumped once per DONE entry; it wraps
    // naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acq_count <= '0;
        end else if (entering_done) begin
            acq_count <= acq_count + ACQ_ONE;
        end
    end

endmodule

// File: doc/averager_sequencer.md
Name: averager_sequencer

Overview:
Run controller for the averaging core (din/tvalid/restart/n_avg/ready interface). It arms the averager with a one-cycle restart and gates the sample-valid stream into it. It stops accumulation once a host-programmed number of averages is reached, then holds the result until host readout is acknowledged. Single-shot and continuous modes, a watchdog, and an acquisition counter are exposed to the host register bank.

Parameters:
WIDTH, 8, log2 of samples per period; the averager n_avg width is 32-WIDTH
N_WIDTH, 24, width of n_target and n_avg (must equal 32-WIDTH)
TO_WIDTH, 32, width of the watchdog limit/counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  host pulse: begin acquisition
stop  in  1  host pulse: abort to IDLE
continuous  in  1  1 = re-arm automatically after ack
n_target  in  N_WIDTH  averages per acquisition; 0 treated as 1
timeout  in  TO_WIDTH  watchdog limit in clk cycles; 0 = disabled
ack  in  1  host pulse: readout finished
tvalid_in  in  1  ADC sample valid
n_avg  in  N_WIDTH  averager completed-average count
avg_ready  in  1  averager buffer-valid flag
tvalid_out  out  1  gated sample valid to averager
restart  out  1  one-cycle restart pulse to averager
busy  out  1  state not IDLE
done  out  1  result frozen, awaiting ack
timed_out  out  1  sticky watchdog flag
acq_count  out  16  completed acquisitions, wraps
state  out  3  encoded state for debug

Behaviour:
- Reset values: tvalid_out=0, restart=0, busy=0, done=0, timed_out=0, acq_count=0, state=IDLE. All outputs are registered.
- States and encodings: IDLE=0, ARM=1, SETTLE=2, ACCUM=3, DONE=4.
- IDLE: start -> ARM; timed_out clears on start.
- ARM: restart=1 for exactly this one cycle; n_target is latched (0 -> 1); next state SETTLE.
- SETTLE: waits until n_avg==0 (averager has cleared) -> ACCUM; tvalid_out=0 throughout.
- ACCUM:
  - tvalid_out = tvalid_in, registered, 1-cycle latency.
  - Exit when n_avg >= latched target AND avg_ready=1 -> DONE.
  - The comparison is unsigned, full N_WIDTH.
- DONE:
  - tvalid_out forced 0, freezing the buffer; done=1.
  - acq_count increments once on entry and wraps at 0xFFFF -> 0.
  - ack: if continuous=1 -> ARM, else -> IDLE; done drops the cycle after ack.
- Watchdog:
  - Counter resets on entry to SETTLE, counts in SETTLE and ACCUM, and saturates.
  - If timeout!=0 and counter reaches timeout: timed_out=1 (sticky until next start), go to IDLE, tvalid_out=0.
- Priorities:
  - rst > stop > watchdog > ack/start/exit conditions.
  - stop in any state -> IDLE next cycle, restart=0, done=0, acq_count unchanged.
  - start while not IDLE is ignored; ack outside DONE is ignored.
  - start and stop in the same cycle -> stop wins (stays IDLE).
- n_target and continuous may change at any time. n_target takes effect at the next ARM; continuous is sampled at ack.
- rst mid-acquisition: everything returns to reset values next edge; no restart pulse is issued.

Test Plan:
- Single shot: n_target=4, continuous=0, start pulse -> one restart pulse the cycle after start. tvalid_out follows tvalid_in in ACCUM. done=1 once n_avg reaches 4 with avg_ready=1; acq_count=1. ack -> IDLE, busy=0.
- Continuous: n_target=2, continuous=1; ack three times -> three restart pulses, acq_count=3. Then clear continuous before the 4th ack -> IDLE after it.
- n_target=0 -> behaves as 1: done asserts at n_avg=1. ack before DONE is ignored; start while ACCUM is ignored (no extra restart).
- Watchdog: timeout=1000, tvalid_in held 0 so n_avg never advances -> timed_out=1 at cycle 1000 after SETTLE entry, state=IDLE. Next start clears timed_out.
- Abort/priority: start+stop in the same cycle -> stays IDLE. stop during ACCUM -> IDLE next cycle, tvalid_out=0, acq_count unchanged.
- rst asserted in DONE -> done=0, acq_count=0, state=0 next edge. acq_count wrap: preload 0xFFFF via 65535 runs (or force) -> next DONE gives 0.
